// File: rtl/ifetch_q_if.sv
// Fetch-unit bundle: memory request/response side plus the decode handshake.
// The master modport is the fetch unit; the slave modport is its environment.
interface ifetch_q_if #(
    parameter int unsigned ADDR = 16,
    parameter int unsigned WORD = 32
);
    logic            mem_req_o;
    logic [ADDR-1:0] mem_addr_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [WORD-1:0] mem_rdata_i;
    logic            branch_i;
    logic [ADDR-1:0] branch_addr_i;
    logic            inst_valid_o;
    logic            inst_ready_i;
    logic [WORD-1:0] inst_o;
    logic [ADDR-1:0] inst_addr_o;

    modport master (
        output mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, branch_i, branch_addr_i, inst_ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, branch_i, branch_addr_i, inst_ready_i
    );
endinterface

// File: rtl/ifetch_q.sv
// Prefetching instruction-fetch unit: keeps up to DEPTH requests in flight to a
// pipelined in-order memory, buffers responses and hands them to decode.
// A branch flushes the queue and marks every outstanding response as stale.
module ifetch_q #(
    parameter int unsigned ADDR     = 16,
    parameter int unsigned WORD     = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic        clk,
    input  logic        rst,
    ifetch_q_if.master  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic            run_q;
    logic [ADDR-1:0] fpc_q, fpc_d;
    logic [ADDR-1:0] addr_q [DEPTH];
    logic [ADDR-1:0] addr_d [DEPTH];
    logic [WORD-1:0] data_q [DEPTH];
    logic [WORD-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    ptr_t head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;
    cnt_t occ_q, occ_d, inflight_q, inflight_d, drop_q, drop_d;

    logic issue, grant, resp, deliver, pop;

    // Handshake qualifiers; run_q holds requests off until the first edge after reset.
    always_comb begin
        issue   = run_q && !bus.branch_i && (occ_q < cnt_t'(DEPTH))
                  && (inflight_q < cnt_t'(DEPTH));
        grant   = issue && bus.mem_gnt_i;
        resp    = bus.mem_rvalid_i;
        deliver = filled_q[head_q] && !bus.branch_i;
        pop     = deliver && bus.inst_ready_i;
    end

    // Next-state: branch flushes everything, otherwise pop/fill/allocate with net counts.
    always_comb begin
        fpc_d      = fpc_q;
        addr_d     = addr_q;
        data_d     = data_q;
        filled_d   = filled_q;
        head_d     = head_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        occ_d      = occ_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (bus.branch_i) begin
            fpc_d      = bus.branch_addr_i;
            filled_d   = '0;
            head_d     = '0;
            alloc_d    = '0;
            fill_d     = '0;
            occ_d      = '0;
            // A response landing in the branch cycle is already discarded.
            inflight_d = inflight_q - cnt_t'(resp);
            drop_d     = inflight_q - cnt_t'(resp);
        end else begin
            if (pop) begin
                // Clear so an empty queue never shows a stale head as valid.
                filled_d[head_q] = 1'b0;
                head_d           = head_q + ptr_t'(1);
            end
            if (resp) begin
                inflight_d = inflight_d - cnt_t'(1);
                if (drop_q != '0) begin
                    drop_d = drop_q - cnt_t'(1);
                end else begin
                    data_d[fill_q]   = bus.mem_rdata_i;
                    filled_d[fill_q] = 1'b1;
                    fill_d           = fill_q + ptr_t'(1);
                end
            end
            if (grant) begin
                addr_d[alloc_q]   = fpc_q;
                filled_d[alloc_q] = 1'b0;
                alloc_d           = alloc_q + ptr_t'(1);
                inflight_d        = inflight_d + cnt_t'(1);
                fpc_d             = fpc_q + ADDR'(1);
            end
            occ_d = occ_q + cnt_t'(grant) - cnt_t'(pop);
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b0;
            fpc_q      <= ADDR'(RESET_PC);
            addr_q     <= '{default: '0};
            data_q     <= '{default: '0};
            filled_q   <= '0;
            head_q     <= '0;
            alloc_q    <= '0;
            fill_q     <= '0;
            occ_q      <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            run_q      <= 1'b1;
            fpc_q      <= fpc_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            filled_q   <= filled_d;
            head_q     <= head_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // Outputs; head data is zeroed whenever it is not being presented.
    always_comb begin
        bus.mem_req_o    = issue;
        bus.mem_addr_o   = fpc_q;
        bus.inst_valid_o = deliver;
        bus.inst_o       = deliver ? data_q[head_q] : '0;
        bus.inst_addr_o  = deliver ? addr_q[head_q] : '0;
    end
endmodule
